// File: rtl/response_checker.sv
// Response checker: replays a loaded table of (time, expected, mask) entries
// against a free-running time counter, compares the observed response at
// each scheduled time and reports mismatch count, first failure time and
// an overall pass/fail once the whole table has been replayed.
module response_checker #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 8,
   parameter int TW    = 8,
   parameter int CW    = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic             load_valid,
   output logic             load_ready,
   input  logic [TW-1:0]    load_time,
   input  logic [WIDTH-1:0] load_expect,
   input  logic [WIDTH-1:0] load_mask,
   output logic             load_err,
   input  logic             start,
   input  logic [WIDTH-1:0] resp,
   output logic [TW-1:0]    now,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [CW-1:0]    err_count,
   output logic             first_fail_valid,
   output logic [TW-1:0]    first_fail_time
);

   // Count needs to reach DEPTH itself; the table index only spans 0..DEPTH-1.
   localparam int IW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t           state_q;
   logic [IW-1:0]    count_q;
   logic [IW-1:0]    ptr_q;
   logic [TW-1:0]    now_q;
   logic [TW-1:0]    lastTime_q;
   logic [CW-1:0]    errCount_q;
   logic             firstFailValid_q;
   logic [TW-1:0]    firstFailTime_q;
   logic             loadErr_q;

   logic [TW-1:0]    timeTab_q   [DEPTH];
   logic [WIDTH-1:0] expectTab_q [DEPTH];
   logic [WIDTH-1:0] maskTab_q   [DEPTH];

   logic [PW-1:0]    ptrIdx;
   logic [PW-1:0]    wrIdx;
   logic             tableFull;
   logic             orderOk;
   logic             loadFire;
   logic             loadAccept;
   logic             sampleHit;
   logic [WIDTH-1:0] diffBits;
   logic             sampleMiss;
   logic             lastEntry;
   logic [CW-1:0]    errCount_d;

   assign ptrIdx     = ptr_q[PW-1:0];
   assign wrIdx      = count_q[PW-1:0];
   assign tableFull  = (count_q == IW'(DEPTH));

   // The first entry may carry any time; later ones must strictly increase,
   // which is also what guarantees the run terminates before now wraps.
   assign orderOk    = (count_q == '0) || (load_time > lastTime_q);

   // A start on the same edge as a load takes priority and the load is lost.
   assign loadFire   = (state_q == IDLE) && !tableFull && load_valid && !start;
   assign loadAccept = loadFire && orderOk;

   assign sampleHit  = (state_q == RUN) && (now_q == timeTab_q[ptrIdx]);
   assign diffBits   = (resp ^ expectTab_q[ptrIdx]) & maskTab_q[ptrIdx];
   assign sampleMiss = sampleHit && (diffBits != '0);
   assign lastEntry  = (ptr_q == (count_q - IW'(1)));
   assign errCount_d = (errCount_q == '1) ? errCount_q : (errCount_q + CW'(1));

   assign load_ready       = (state_q == IDLE) && !tableFull;
   assign load_err         = loadErr_q;
   assign now              = now_q;
   assign busy             = (state_q == RUN);
   assign done             = (state_q == DONE);
   assign pass             = (state_q == DONE) && (errCount_q == '0);
   assign err_count        = errCount_q;
   assign first_fail_valid = firstFailValid_q;
   assign first_fail_time  = firstFailTime_q;

   // Expectation storage is plain memory; emptiness is tracked by count_q alone.
   always_ff @(posedge clk) begin
      if (!reset && !clear && loadAccept) begin
         timeTab_q[wrIdx]   <= load_time;
         expectTab_q[wrIdx] <= load_expect;
         maskTab_q[wrIdx]   <= load_mask;
      end
   end

   // Control FSM: loading and start in IDLE, timed replay in RUN, frozen in DONE.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         state_q          <= IDLE;
         count_q          <= '0;
         ptr_q            <= '0;
         now_q            <= '0;
         lastTime_q       <= '0;
         errCount_q       <= '0;
         firstFailValid_q <= 1'b0;
         firstFailTime_q  <= '0;
         loadErr_q        <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (start) begin
                  now_q            <= '0;
                  ptr_q            <= '0;
                  errCount_q       <= '0;
                  firstFailValid_q <= 1'b0;
                  firstFailTime_q  <= '0;
                  state_q          <= (count_q != '0) ? RUN : DONE;
               end else if (loadFire) begin
                  if (orderOk) begin
                     count_q    <= count_q + IW'(1);
                     lastTime_q <= load_time;
                  end else begin
                     loadErr_q  <= 1'b1;
                  end
               end
            end
            RUN: begin
               now_q <= now_q + TW'(1);
               if (sampleHit) begin
                  ptr_q <= ptr_q + IW'(1);
                  if (sampleMiss) begin
                     errCount_q <= errCount_d;
                     if (!firstFailValid_q) begin
                        firstFailValid_q <= 1'b1;
                        firstFailTime_q  <= now_q;
                     end
                  end
                  if (lastEntry) begin
                     state_q <= DONE;
                  end
               end
            end
            DONE: begin
               state_q <= DONE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_response_checker.sv
// Bench for response_checker: directed tables are loaded, runs are started,
// and the expected end-of-run result is queued; a monitor pops and compares
// whenever done rises. A second instance with DEPTH=20 covers saturation.
module tb_response_checker;

   localparam int WIDTH = 2;
   localparam int TW    = 8;
   localparam int CW    = 4;

   typedef struct {
      int pass;
      int err;
      int ffv;
      int fft;
      int lat;
   } exp_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             clear;
   logic [TW-1:0]    loadTime;
   logic [WIDTH-1:0] loadExpect;
   logic [WIDTH-1:0] loadMask;
   logic [WIDTH-1:0] resp;
   logic             aLoadValid, aStart, bLoadValid, bStart;

   logic             aLoadReady, aLoadErr, aBusy, aDone, aPass, aFfv;
   logic [TW-1:0]    aNow, aFft;
   logic [CW-1:0]    aErr;
   logic             bLoadReady, bLoadErr, bBusy, bDone, bPass, bFfv;
   logic [TW-1:0]    bNow, bFft;
   logic [CW-1:0]    bErr;

   int   nCompared   = 0;
   int   nMismatched = 0;
   int   cyc         = 0;
   int   startCycA   = 0;
   int   startCycB   = 0;
   bit   doneSeenA   = 1'b0;
   bit   doneSeenB   = 1'b0;
   exp_t qA[$];
   exp_t qB[$];
   exp_t popA, popB;
   logic [WIDTH-1:0] sched [32];

   response_checker #(.WIDTH(WIDTH), .DEPTH(8), .TW(TW), .CW(CW)) u_dutA (
      .clk(clk), .reset(reset), .clear(clear),
      .load_valid(aLoadValid), .load_ready(aLoadReady),
      .load_time(loadTime), .load_expect(loadExpect), .load_mask(loadMask),
      .load_err(aLoadErr), .start(aStart), .resp(resp), .now(aNow),
      .busy(aBusy), .done(aDone), .pass(aPass), .err_count(aErr),
      .first_fail_valid(aFfv), .first_fail_time(aFft)
   );

   response_checker #(.WIDTH(WIDTH), .DEPTH(20), .TW(TW), .CW(CW)) u_dutB (
      .clk(clk), .reset(reset), .clear(clear),
      .load_valid(bLoadValid), .load_ready(bLoadReady),
      .load_time(loadTime), .load_expect(loadExpect), .load_mask(loadMask),
      .load_err(bLoadErr), .start(bStart), .resp(resp), .now(bNow),
      .busy(bBusy), .done(bDone), .pass(bPass), .err_count(bErr),
      .first_fail_valid(bFfv), .first_fail_time(bFft)
   );

   // Free-running clock and cycle counter used for done-latency checks.
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic checkOutput(input string name, input int actual, input int required);
      nCompared++;
      if (actual != required) begin
         nMismatched++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
      end
   endtask

   // Monitor: on each rising done, pop the queued expectation and compare.
   always @(negedge clk) begin
      if (aDone && !doneSeenA) begin
         if (qA.size() == 0) begin
            checkOutput("A unexpected done", 1, 0);
         end else begin
            popA = qA.pop_front();
            checkOutput("A pass", int'(aPass), popA.pass);
            checkOutput("A err_count", int'(aErr), popA.err);
            checkOutput("A first_fail_valid", int'(aFfv), popA.ffv);
            checkOutput("A first_fail_time", int'(aFft), popA.fft);
            checkOutput("A done latency", cyc - startCycA, popA.lat);
         end
      end
      doneSeenA = aDone;
      if (bDone && !doneSeenB) begin
         if (qB.size() == 0) begin
            checkOutput("B unexpected done", 1, 0);
         end else begin
            popB = qB.pop_front();
            checkOutput("B pass", int'(bPass), popB.pass);
            checkOutput("B err_count", int'(bErr), popB.err);
            checkOutput("B first_fail_valid", int'(bFfv), popB.ffv);
            checkOutput("B first_fail_time", int'(bFft), popB.fft);
            checkOutput("B done latency", cyc - startCycB, popB.lat);
         end
      end
      doneSeenB = bDone;
   end

   task automatic fillSched(input logic [WIDTH-1:0] v);
      for (int i = 0; i < 32; i++) sched[i] = v;
   endtask

   task automatic loadEntry(input bit toB, input int t, input logic [WIDTH-1:0] e,
                            input logic [WIDTH-1:0] m);
      @(negedge clk);
      loadTime   = TW'(t);
      loadExpect = e;
      loadMask   = m;
      aLoadValid = !toB;
      bLoadValid = toB;
      @(negedge clk);
      aLoadValid = 1'b0;
      bLoadValid = 1'b0;
   endtask

   task automatic doClear();
      @(negedge clk);
      clear = 1'b1;
      @(negedge clk);
      clear = 1'b0;
   endtask

   // Starts a run, queues its expected result, replays sched up to lastT
   // and waits (bounded) for done, leaving one cycle for the monitor.
   task automatic applyStimulus(input bit toB, input int lastT, input exp_t e);
      bit seen;
      @(negedge clk);
      if (toB) begin
         startCycB = cyc + 1;
         qB.push_back(e);
         bStart = 1'b1;
      end else begin
         startCycA = cyc + 1;
         qA.push_back(e);
         aStart = 1'b1;
      end
      for (int k = 0; k <= lastT; k++) begin
         @(negedge clk);
         aStart = 1'b0;
         bStart = 1'b0;
         resp   = sched[k];
         if (k == 0) begin
            checkOutput("busy in run", int'(toB ? bBusy : aBusy), 1);
            checkOutput("load_ready in run", int'(toB ? bLoadReady : aLoadReady), 0);
         end
      end
      seen = 1'b0;
      for (int w = 0; w < 64 && !seen; w++) begin
         @(negedge clk);
         aStart = 1'b0;
         bStart = 1'b0;
         seen = toB ? bDone : aDone;
      end
      if (!seen) checkOutput("done timeout", 0, 1);
      @(negedge clk);
   endtask

   initial begin
      #400000;
      $display("[TB] FAIL global timeout: got running, expected finished");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      exp_t e;
      reset = 1'b1; clear = 1'b0; aLoadValid = 1'b0; bLoadValid = 1'b0;
      aStart = 1'b0; bStart = 1'b0; resp = '0;
      loadTime = '0; loadExpect = '0; loadMask = '0;
      repeat (2) @(negedge clk);
      checkOutput("reset load_ready", int'(aLoadReady), 1);
      checkOutput("reset load_err", int'(aLoadErr), 0);
      checkOutput("reset now", int'(aNow), 0);
      checkOutput("reset busy", int'(aBusy), 0);
      checkOutput("reset done", int'(aDone), 0);
      checkOutput("reset pass", int'(aPass), 0);
      checkOutput("reset err_count", int'(aErr), 0);
      checkOutput("reset first_fail_valid", int'(aFfv), 0);
      reset = 1'b0;

      // All four samples match.
      loadEntry(0, 0, 2'b00, 2'b11);
      loadEntry(0, 2, 2'b01, 2'b11);
      loadEntry(0, 4, 2'b10, 2'b11);
      loadEntry(0, 6, 2'b11, 2'b11);
      fillSched(2'b00);
      sched[2] = 2'b01; sched[4] = 2'b10; sched[6] = 2'b11;
      e = '{pass: 1, err: 0, ffv: 0, fft: 0, lat: 7};
      applyStimulus(0, 6, e);

      // Wrong values at 4 and 6: first failure stays at 4.
      doClear();
      checkOutput("clear done", int'(aDone), 0);
      checkOutput("clear load_ready", int'(aLoadReady), 1);
      loadEntry(0, 0, 2'b00, 2'b11);
      loadEntry(0, 2, 2'b01, 2'b11);
      loadEntry(0, 4, 2'b10, 2'b11);
      loadEntry(0, 6, 2'b11, 2'b11);
      fillSched(2'b00);
      sched[2] = 2'b01;
      e = '{pass: 0, err: 2, ffv: 1, fft: 4, lat: 7};
      applyStimulus(0, 6, e);
      @(negedge clk) aStart = 1'b1;
      @(negedge clk) aStart = 1'b0;
      checkOutput("start ignored in DONE done", int'(aDone), 1);
      checkOutput("start ignored in DONE err", int'(aErr), 2);

      // Mask: resp=11 vs expect=01 differs only in bit1.
      doClear();
      checkOutput("clear err_count", int'(aErr), 0);
      loadEntry(0, 2, 2'b01, 2'b01);
      fillSched(2'b11);
      e = '{pass: 1, err: 0, ffv: 0, fft: 0, lat: 3};
      applyStimulus(0, 2, e);
      doClear();
      loadEntry(0, 2, 2'b01, 2'b10);
      e = '{pass: 0, err: 1, ffv: 1, fft: 2, lat: 3};
      applyStimulus(0, 2, e);

      // Ordering error, then fill the table and offer a ninth entry.
      doClear();
      loadEntry(0, 5, 2'b01, 2'b11);
      loadEntry(0, 3, 2'b11, 2'b11);
      checkOutput("non-increasing load_err", int'(aLoadErr), 1);
      checkOutput("after reject load_ready", int'(aLoadReady), 1);
      for (int t = 6; t <= 12; t++) loadEntry(0, t, WIDTH'(t & 3), 2'b11);
      checkOutput("full load_ready", int'(aLoadReady), 0);
      loadEntry(0, 13, 2'b01, 2'b11);
      checkOutput("ninth ignored load_ready", int'(aLoadReady), 0);
      checkOutput("load_err sticky", int'(aLoadErr), 1);
      for (int t = 0; t < 32; t++) sched[t] = WIDTH'(t & 3);
      e = '{pass: 1, err: 0, ffv: 0, fft: 0, lat: 13};
      applyStimulus(0, 12, e);
      doClear();
      checkOutput("clear load_err", int'(aLoadErr), 0);

      // Saturation on the 20-deep instance.
      for (int t = 0; t < 20; t++) loadEntry(1, t, 2'b00, 2'b11);
      checkOutput("B full load_ready", int'(bLoadReady), 0);
      fillSched(2'b11);
      e = '{pass: 0, err: 15, ffv: 1, fft: 0, lat: 20};
      applyStimulus(1, 19, e);

      // Empty table goes straight to DONE with pass.
      doClear();
      e = '{pass: 1, err: 0, ffv: 0, fft: 0, lat: 0};
      applyStimulus(0, -1, e);

      // Reset during RUN at now=3 aborts and empties the table.
      doClear();
      loadEntry(0, 0, 2'b00, 2'b11);
      loadEntry(0, 5, 2'b01, 2'b11);
      @(negedge clk) aStart = 1'b1;
      for (int k = 0; k <= 3; k++) begin
         @(negedge clk);
         aStart = 1'b0;
         resp   = (k == 0) ? 2'b11 : 2'b00;
         if (k == 3) begin
            checkOutput("pre-abort now", int'(aNow), 3);
            checkOutput("pre-abort err_count", int'(aErr), 1);
            reset = 1'b1;
         end
      end
      @(negedge clk);
      reset = 1'b0;
      checkOutput("abort busy", int'(aBusy), 0);
      checkOutput("abort now", int'(aNow), 0);
      checkOutput("abort err_count", int'(aErr), 0);
      checkOutput("abort first_fail_valid", int'(aFfv), 0);
      checkOutput("abort load_ready", int'(aLoadReady), 1);
      e = '{pass: 1, err: 0, ffv: 0, fft: 0, lat: 0};
      applyStimulus(0, -1, e);

      checkOutput("A queue drained", qA.size(), 0);
      checkOutput("B queue drained", qB.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
      $finish;
   end

endmodule
